// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with same-cycle write bypass,
// a per-register busy scoreboard and a post-reset clear sequencer.
//
// state   | meaning
// S_CLEAR | zeroing entry[r_idx] each cycle; writes/allocs ignored, rd/rbusy held 0
// S_READY | normal operation until the next reset
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREAD*AW-1:0]    ra,
    output logic [NREAD*XLEN-1:0]  rd,
    output logic [NREAD-1:0]       rbusy,
    input  logic [NWRITE-1:0]      we,
    input  logic [NWRITE*AW-1:0]   wa,
    input  logic [NWRITE*XLEN-1:0] wd,
    input  logic                   alloc_en,
    input  logic [AW-1:0]          alloc_addr,
    output logic                   ready
);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_idx;
    logic [AW-1:0]     w_idx_nxt;
    logic [XLEN-1:0]   r_mem [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic [NWRITE-1:0] w_wen;
    logic              w_hit;

    assign ready = (r_state == S_READY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (r_state == S_CLEAR) begin
            if (r_idx == AW'(NREGS - 1)) begin
                w_state_nxt = S_READY;
            end else begin
                w_idx_nxt = r_idx + 1'b1;
            end
        end
    end

    // A write port is effective only once cleared and never for x0.
    always_comb begin
        w_wen = '0;
        for (int k = 0; k < NWRITE; k++) begin
            w_wen[k] = ready && we[k] && (wa[k*AW +: AW] != '0);
        end
    end

    // Storage has no reset; the clear sequence provides the defined contents.
    always_ff @(posedge clk) begin
        if (!ready) begin
            r_mem[r_idx] <= '0;
        end else begin
            for (int k = 0; k < NWRITE; k++) begin
                if (w_wen[k]) begin
                    r_mem[wa[k*AW +: AW]] <= wd[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Alloc is applied after the write-side clears so it wins on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else if (ready) begin
            for (int k = 0; k < NWRITE; k++) begin
                if (w_wen[k]) begin
                    r_busy[wa[k*AW +: AW]] <= 1'b0;
                end
            end
            if (alloc_en && (alloc_addr != '0)) begin
                r_busy[alloc_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd    = '0;
        rbusy = '0;
        w_hit = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            w_hit = 1'b0;
            if (ready && (ra[p*AW +: AW] != '0)) begin
                rd[p*XLEN +: XLEN] = r_mem[ra[p*AW +: AW]];
                for (int k = 0; k < NWRITE; k++) begin
                    if (w_wen[k] && (wa[k*AW +: AW] == ra[p*AW +: AW])) begin
                        rd[p*XLEN +: XLEN] = wd[k*XLEN +: XLEN];
                        w_hit              = 1'b1;
                    end
                end
                rbusy[p] = r_busy[ra[p*AW +: AW]] & ~w_hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: clear sequence, bypass, conflicts,
// x0 handling, scoreboard timing and asynchronous reset mid-run.
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int AW     = 5;
    localparam int NV     = 19;

    logic                   clk;
    logic                   rst_n;
    logic [NREAD*AW-1:0]    ra;
    logic [NREAD*XLEN-1:0]  rd;
    logic [NREAD-1:0]       rbusy;
    logic [NWRITE-1:0]      we;
    logic [NWRITE*AW-1:0]   wa;
    logic [NWRITE*XLEN-1:0] wd;
    logic                   alloc_en;
    logic [AW-1:0]          alloc_addr;
    logic                   ready;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ra         (ra),
        .rd         (rd),
        .rbusy      (rbusy),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        al_en;
        logic [4:0]  al_a;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_rb;
    } vec_t;

    typedef struct {
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  rb;
        int          id;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] i_we, input logic [4:0] a0, input logic [31:0] d0,
                                input logic [4:0] a1, input logic [31:0] d1,
                                input logic aen, input logic [4:0] aa,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb);
        vec_t v;
        v.we = i_we; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
        v.al_en = aen; v.al_a = aa; v.ra0 = r0; v.ra1 = r1;
        v.e_rd0 = e0; v.e_rd1 = e1; v.e_rb = eb;
        return v;
    endfunction

    task automatic drive(input logic [1:0] i_we, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1,
                         input logic aen, input logic [4:0] aa,
                         input logic [4:0] r0, input logic [4:0] r1);
        we         = i_we;
        wa         = {a1, a0};
        wd         = {d1, d0};
        alloc_en   = aen;
        alloc_addr = aa;
        ra         = {r1, r0};
    endtask

    // Counts samples with ready low after reset release; optionally pokes
    // writes/allocs during the first cycles of the clear sequence.
    task automatic wait_ready(input bit poke, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clk);
            if (poke && c == 0) drive(2'b01, 5'd5, 32'hAAAA_5555, 5'd0, 32'h0, 1'b1, 5'd6, 5'd5, 5'd6);
            if (poke && c == 10) drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
            #2;
            if (poke && c == 3) begin
                chk("clear_rd_bypass_blocked", rd[31:0], 32'h0);
                chk("clear_rbusy_zero", {30'h0, rbusy}, 32'h0);
            end
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
    endtask

    function automatic logic [31:0] pat(input int r);
        return 32'hC0DE_0000 | r;
    endfunction

    initial begin
        int  n;
        bit  ok;
        exp_t e;

        vecs[0]  = mk(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00);
        vecs[1]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
        vecs[2]  = mk(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd5, 32'h22, 32'hDEADBEEF, 2'b00);
        vecs[3]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h22, 32'h22, 2'b00);
        vecs[4]  = mk(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00);
        vecs[5]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0, 32'h22, 2'b00);
        vecs[6]  = mk(2'b11, 5'd10, 32'hA0A0, 5'd11, 32'hB1B1, 1'b0, 5'd0, 5'd11, 5'd10, 32'hB1B1, 32'hA0A0, 2'b00);
        vecs[7]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd11, 32'hA0A0, 32'hB1B1, 2'b00);
        vecs[8]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9, 32'h0, 32'h0, 2'b00);
        vecs[9]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h0, 32'h0, 2'b11);
        vecs[10] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd10, 32'h0, 32'hA0A0, 2'b01);
        vecs[11] = mk(2'b10, 5'd0, 32'h0, 5'd9, 32'h99, 1'b0, 5'd0, 5'd9, 5'd9, 32'h99, 32'h99, 2'b00);
        vecs[12] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h99, 32'h99, 2'b00);
        vecs[13] = mk(2'b01, 5'd9, 32'h55, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9, 32'h55, 32'h55, 2'b00);
        vecs[14] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h55, 32'h55, 2'b11);
        vecs[15] = mk(2'b11, 5'd9, 32'h66, 5'd12, 32'h77, 1'b1, 5'd12, 5'd9, 5'd12, 32'h66, 32'h77, 2'b00);
        vecs[16] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd12, 32'h66, 32'h77, 2'b10);
        vecs[17] = mk(2'b11, 5'd13, 32'h13, 5'd0, 32'hFFFF, 1'b0, 5'd0, 5'd0, 5'd13, 32'h0, 32'h13, 2'b00);
        vecs[18] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd13, 5'd0, 32'h13, 32'h0, 2'b00);

        rst_n = 1'b0;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
        repeat (2) @(negedge clk);
        #2;
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_rd0", rd[31:0], 32'h0);
        chk("rst_rd1", rd[63:32], 32'h0);
        chk("rst_rbusy", {30'h0, rbusy}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(1'b1, n, ok);
        chk("clear_ready_timeout", {31'h0, ok}, 32'h1);
        chk("clear_cycles", n, NREGS);

        for (int r = 1; r < NREGS; r++) begin
            @(negedge clk);
            drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(r), 5'd6);
            #2;
            chk($sformatf("cleared_x%0d", r), rd[31:0], 32'h0);
            chk($sformatf("cleared_rbusy_x%0d", r), {30'h0, rbusy}, 32'h0);
        end

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
                  vecs[i].al_en, vecs[i].al_a, vecs[i].ra0, vecs[i].ra1);
            sb_q.push_back('{vecs[i].e_rd0, vecs[i].e_rd1, vecs[i].e_rb, i});
            #2;
            if (sb_q.size() == 0) begin
                chk("scoreboard_underflow", 32'h0, 32'h1);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("v%0d_rd0", e.id), rd[31:0], e.rd0);
                chk($sformatf("v%0d_rd1", e.id), rd[63:32], e.rd1);
                chk($sformatf("v%0d_rbusy", e.id), {30'h0, rbusy}, {30'h0, e.rb});
            end
        end

        for (int r = 1; r < NREGS; r++) begin
            @(negedge clk);
            drive(2'b01, 5'(r), pat(r), 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        end
        @(negedge clk);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd31);
        @(negedge clk);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd31);
        #2;
        chk("prerst_ready", {31'h0, ready}, 32'h1);
        chk("prerst_rbusy", {30'h0, rbusy}, 32'h1);
        chk("prerst_x3", rd[31:0], pat(3));
        chk("prerst_x31", rd[63:32], pat(31));

        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'h0, ready}, 32'h0);
        chk("midrst_rbusy", {30'h0, rbusy}, 32'h0);
        chk("midrst_rd0", rd[31:0], 32'h0);
        chk("midrst_rd1", rd[63:32], 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(1'b0, n, ok);
        chk("reclear_ready_timeout", {31'h0, ok}, 32'h1);
        chk("reclear_cycles", n, NREGS);

        for (int r = 1; r < NREGS; r++) begin
            @(negedge clk);
            drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(r), 5'd3);
            #2;
            chk($sformatf("recleared_x%0d", r), rd[31:0], 32'h0);
            chk($sformatf("recleared_rbusy_x%0d", r), {30'h0, rbusy}, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
